clint_ctrl: RTL and testbench

CLINT_CTRL -- requirements
Module: clint_ctrl

---
 rtl/clint_ctrl.sv | 146 ++++++++++++++
 tb/tb_clint_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/clint_ctrl.sv
// Core-local interrupt controller: sequences trap/return CSR writes (mepc, mcause,
// mstatus) and issues a one-cycle pipeline redirect to mtvec or mepc.
module clint_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [63:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [63:0] jump_addr_i,
    input  logic        int_flag_i,
    input  logic [63:0] csr_mtvec_i,
    input  logic [63:0] csr_mepc_i,
    input  logic [63:0] csr_mstatus_i,
    input  logic        global_int_en_i,
    output logic        we_o,
    output logic [63:0] waddr_o,
    output logic [63:0] raddr_o,
    output logic [63:0] data_o,
    output logic        hold_flag_o,
    output logic        int_assert_o,
    output logic [63:0] int_addr_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [63:0] CSR_MSTATUS = 64'h300;
    localparam logic [63:0] CSR_MEPC    = 64'h341;
    localparam logic [63:0] CSR_MCAUSE  = 64'h342;

    localparam logic [63:0] CAUSE_ECALL  = 64'd11;
    localparam logic [63:0] CAUSE_EBREAK = 64'd3;
    localparam logic [63:0] CAUSE_TIMER  = 64'h8000_0000_0000_0007;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MSTATUS,
        W_MRET,
        ASSERT
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] epc_q, epc_d;
    logic [63:0] cause_q, cause_d;
    logic [63:0] target_q, target_d;

    logic is_ecall, is_ebreak, is_mret, int_req;

    assign is_ecall  = (inst_i == INST_ECALL);
    assign is_ebreak = (inst_i == INST_EBREAK);
    assign is_mret   = (inst_i == INST_MRET);
    assign int_req   = int_flag_i & global_int_en_i;
    assign raddr_o   = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            epc_q    <= '0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        target_d     = target_q;
        we_o         = 1'b0;
        waddr_o      = '0;
        data_o       = '0;
        hold_flag_o  = 1'b0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;

        case (state_q)
            IDLE: begin
                // Synchronous traps and MRET win; a level interrupt stays pending until then.
                if (is_ecall || is_ebreak) begin
                    state_d     = W_MEPC;
                    epc_d       = inst_addr_i;
                    cause_d     = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                    hold_flag_o = ~rst;
                end else if (is_mret) begin
                    state_d     = W_MRET;
                    hold_flag_o = ~rst;
                end else if (int_req) begin
                    state_d     = W_MEPC;
                    epc_d       = jump_flag_i ? jump_addr_i : inst_addr_i;
                    cause_d     = CAUSE_TIMER;
                    hold_flag_o = ~rst;
                end
            end
            W_MEPC: begin
                we_o        = 1'b1;
                waddr_o     = CSR_MEPC;
                data_o      = epc_q;
                hold_flag_o = 1'b1;
                state_d     = W_MCAUSE;
            end
            W_MCAUSE: begin
                we_o        = 1'b1;
                waddr_o     = CSR_MCAUSE;
                data_o      = cause_q;
                hold_flag_o = 1'b1;
                state_d     = W_MSTATUS;
            end
            W_MSTATUS: begin
                we_o        = 1'b1;
                waddr_o     = CSR_MSTATUS;
                data_o      = csr_mstatus_i;
                data_o[7]   = csr_mstatus_i[3];
                data_o[3]   = 1'b0;
                hold_flag_o = 1'b1;
                target_d    = csr_mtvec_i;
                state_d     = ASSERT;
            end
            W_MRET: begin
                we_o        = 1'b1;
                waddr_o     = CSR_MSTATUS;
                data_o      = csr_mstatus_i;
                data_o[3]   = csr_mstatus_i[7];
                data_o[7]   = 1'b1;
                hold_flag_o = 1'b1;
                target_d    = csr_mepc_i;
                state_d     = ASSERT;
            end
            ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = target_q;
                hold_flag_o  = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_clint_ctrl.sv
// Table-driven, scoreboarded bench for clint_ctrl: each row is one cycle of inputs
// plus the outputs expected in that cycle.
module tb_clint_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [63:0] A_MST  = 64'h300;
    localparam logic [63:0] A_EPC  = 64'h341;
    localparam logic [63:0] A_CAU  = 64'h342;
    localparam logic [63:0] C_TMR  = 64'h8000_0000_0000_0007;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_i = '0;
    logic [63:0] inst_addr_i = '0, jump_addr_i = '0;
    logic        jump_flag_i = 1'b0, int_flag_i = 1'b0, global_int_en_i = 1'b0;
    logic [63:0] csr_mtvec_i = '0, csr_mepc_i = '0, csr_mstatus_i = '0;
    logic        we_o, hold_flag_o, int_assert_o;
    logic [63:0] waddr_o, raddr_o, data_o, int_addr_o;

    clint_ctrl dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .int_flag_i(int_flag_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
        .global_int_en_i(global_int_en_i), .we_o(we_o), .waddr_o(waddr_o), .raddr_o(raddr_o),
        .data_o(data_o), .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o),
        .int_addr_o(int_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [63:0] waddr;
        logic [63:0] raddr;
        logic [63:0] data;
        logic        hold;
        logic        ia;
        logic [63:0] iaddr;
    } out_t;

    typedef struct {
        logic        rst;
        logic [31:0] inst;
        logic [63:0] pc;
        logic        jf;
        logic [63:0] ja;
        logic        intf;
        logic        gie;
        logic [63:0] mtvec, mepc, mstatus;
        out_t        exp;
    } vec_t;

    vec_t tbl[$];
    out_t exp_q[$];
    int   n_assert = 0;
    int   n_fail = 0;

    // Environment applied to rows built by mk()
    logic [63:0] e_pc = '0, e_ja = '0, e_mtvec = '0, e_mepc = '0, e_mst = '0;
    logic        e_jf = 1'b0;

    function automatic vec_t mk(logic r, logic [31:0] ins, logic intf, logic gie,
                                logic we, logic [63:0] wa, logic [63:0] d,
                                logic h, logic ia, logic [63:0] iad);
        vec_t v;
        v.rst = r; v.inst = ins; v.pc = e_pc; v.jf = e_jf; v.ja = e_ja;
        v.intf = intf; v.gie = gie; v.mtvec = e_mtvec; v.mepc = e_mepc; v.mstatus = e_mst;
        v.exp = '{we: we, waddr: wa, raddr: 64'h0, data: d, hold: h, ia: ia, iaddr: iad};
        return v;
    endfunction

    function automatic vec_t idle0(logic r);
        return mk(r, NOP, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endfunction

    task automatic check_out(input string tag);
        out_t got, e;
        got = '{we: we_o, waddr: waddr_o, raddr: raddr_o, data: data_o,
                hold: hold_flag_o, ia: int_assert_o, iaddr: int_addr_o};
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got we=%0b waddr=%h data=%h hold=%0b ia=%0b iaddr=%h raddr=%h; want we=%0b waddr=%h data=%h hold=%0b ia=%0b iaddr=%h raddr=%h",
                         tag, got.we, got.waddr, got.data, got.hold, got.ia, got.iaddr, got.raddr,
                         e.we, e.waddr, e.data, e.hold, e.ia, e.iaddr, e.raddr);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        rst = v.rst; inst_i = v.inst; inst_addr_i = v.pc; jump_flag_i = v.jf;
        jump_addr_i = v.ja; int_flag_i = v.intf; global_int_en_i = v.gie;
        csr_mtvec_i = v.mtvec; csr_mepc_i = v.mepc; csr_mstatus_i = v.mstatus;
        exp_q.push_back(v.exp);
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    initial begin
        int lat;
        logic [63:0] seen_addr;

        // Reset holds everything low even with triggers present
        e_pc = 64'h8000_0010; e_mtvec = 64'h8000_0100; e_mst = 64'h8;
        tbl.push_back(mk(1, ECALL, 1, 1, 0, '0, '0, 0, 0, '0));
        tbl.push_back(idle0(0));
        // ECALL trap
        tbl.push_back(mk(0, ECALL, 0, 0, 0, '0, '0, 1, 0, '0));
        e_pc = 64'h8000_0014;
        tbl.push_back(mk(0, NOP, 0, 0, 1, A_EPC, 64'h8000_0010, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 0, 1, A_CAU, 64'd11, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 0, 1, A_MST, 64'h80, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, '0, '0, 1, 1, 64'h8000_0100));
        tbl.push_back(idle0(0));
        // MRET return
        e_mst = 64'h80; e_mepc = 64'h8000_0014;
        tbl.push_back(mk(0, MRET, 0, 0, 0, '0, '0, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 0, 1, A_MST, 64'h88, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, '0, '0, 1, 1, 64'h8000_0014));
        tbl.push_back(idle0(0));
        // Timer interrupt on a taken jump: epc comes from the jump target
        e_pc = 64'h8000_0020; e_jf = 1; e_ja = 64'h8000_0200; e_mst = 64'h88;
        tbl.push_back(mk(0, NOP, 1, 1, 0, '0, '0, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 1, 1, 1, A_EPC, 64'h8000_0200, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 1, 1, 1, A_CAU, C_TMR, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 1, 1, 1, A_MST, 64'h80, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 1, 1, 0, '0, '0, 1, 1, 64'h8000_0100));
        e_jf = 0;
        tbl.push_back(idle0(0));
        // Timer interrupt without jump, mstatus with unrelated bits set
        e_pc = 64'h8000_0030; e_mst = 64'hA000_0000_0000_1808;
        tbl.push_back(mk(0, NOP, 1, 1, 0, '0, '0, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 1, 1, A_EPC, 64'h8000_0030, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 1, 1, A_CAU, C_TMR, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 1, 1, A_MST, 64'hA000_0000_0000_1880, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 1, 0, '0, '0, 1, 1, 64'h8000_0100));
        // Interrupt masked
        tbl.push_back(mk(0, NOP, 1, 0, 0, '0, '0, 0, 0, '0));
        tbl.push_back(mk(0, NOP, 1, 0, 0, '0, '0, 0, 0, '0));
        // ECALL with simultaneous interrupt: ECALL cause wins
        e_pc = 64'h8000_0040; e_mst = 64'h8;
        tbl.push_back(mk(0, ECALL, 1, 1, 0, '0, '0, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 1, 1, A_EPC, 64'h8000_0040, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 1, 1, A_CAU, 64'd11, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 1, 1, A_MST, 64'h80, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 1, 0, '0, '0, 1, 1, 64'h8000_0100));
        // EBREAK; mtvec changes after the mstatus write and must not leak through
        e_pc = 64'h8000_0050; e_mst = 64'h1888; e_mtvec = 64'h8000_0400;
        tbl.push_back(mk(0, EBREAK, 0, 0, 0, '0, '0, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 0, 1, A_EPC, 64'h8000_0050, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 0, 1, A_CAU, 64'd3, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 0, 1, A_MST, 64'h1880, 1, 0, '0));
        e_mtvec = 64'h0000_0BAD;
        tbl.push_back(mk(0, NOP, 0, 0, 0, '0, '0, 1, 1, 64'h8000_0400));
        // MRET with pending interrupt: return first, then the interrupt is taken
        e_mst = 64'h80; e_mepc = 64'h8000_0060; e_mtvec = 64'h8000_0100; e_pc = 64'h8000_0060;
        tbl.push_back(mk(0, MRET, 1, 1, 0, '0, '0, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 1, 1, 1, A_MST, 64'h88, 1, 0, '0));
        e_mepc = 64'h0;
        tbl.push_back(mk(0, NOP, 1, 1, 0, '0, '0, 1, 1, 64'h8000_0060));
        e_mst = 64'h88;
        tbl.push_back(mk(0, NOP, 1, 1, 0, '0, '0, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 1, 1, A_EPC, 64'h8000_0060, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 1, 1, A_CAU, C_TMR, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 1, 1, A_MST, 64'h80, 1, 0, '0));
        tbl.push_back(mk(0, NOP, 0, 1, 0, '0, '0, 1, 1, 64'h8000_0100));
        tbl.push_back(idle0(0));

        // Row 0 carries reset: apply it before the first edge
        #1;
        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Reset during W_MCAUSE abandons the sequence without a redirect
        e_pc = 64'h8000_0070; e_mst = 64'h8; e_mtvec = 64'h8000_0100;
        apply(mk(0, ECALL, 0, 0, 0, '0, '0, 1, 0, '0), "mr_trig");
        apply(mk(0, NOP, 0, 0, 1, A_EPC, 64'h8000_0070, 1, 0, '0), "mr_mepc");
        apply(mk(0, NOP, 0, 0, 1, A_CAU, 64'd11, 1, 0, '0), "mr_mcause");
        #1 rst = 1'b1;
        #1 exp_q.push_back('0);
        check_out("mr_async");
        apply(idle0(1), "mr_hold");
        for (int i = 0; i < 4; i++) apply(idle0(0), $sformatf("mr_post%0d", i));
        e_pc = 64'h8000_0074;
        apply(mk(0, ECALL, 0, 0, 0, '0, '0, 1, 0, '0), "mr_retrig");
        apply(mk(0, NOP, 0, 0, 1, A_EPC, 64'h8000_0074, 1, 0, '0), "mr_remepc");
        apply(mk(0, NOP, 0, 0, 1, A_CAU, 64'd11, 1, 0, '0), "mr_recause");
        apply(mk(0, NOP, 0, 0, 1, A_MST, 64'h80, 1, 0, '0), "mr_remst");
        apply(mk(0, NOP, 0, 0, 0, '0, '0, 1, 1, 64'h8000_0100), "mr_reassert");

        // Bounded wait: interrupt redirect must arrive four cycles after the trigger
        @(posedge clk);
        #1;
        inst_i = NOP; inst_addr_i = 64'h8000_0080; int_flag_i = 1'b1; global_int_en_i = 1'b1;
        csr_mtvec_i = 64'h8000_0180; csr_mstatus_i = 64'h8;
        lat = 0; seen_addr = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (int_assert_o) begin
                seen_addr = int_addr_o;
                break;
            end
            lat = c;
            @(posedge clk);
            #1 int_flag_i = 1'b0;
        end
        chk64("irq_latency", 64'(lat + 1), 64'd5);
        chk64("irq_target", seen_addr, 64'h8000_0180);
        apply(idle0(0), "irq_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
